// File: rtl/delay_tap_switch_ctrl_if.sv
// Tap-change request handshake for delay_tap_switch_ctrl.
// The requester drives valid/tap and the controller answers with ready.
interface delay_tap_switch_ctrl_if #(
  parameter int TAPW = 2
);
  logic            req_valid;
  logic [TAPW-1:0] req_tap;
  logic            req_ready;

  modport master (output req_valid, req_tap, input  req_ready);
  modport slave  (input  req_valid, req_tap, output req_ready);
endinterface

// File: rtl/delay_tap_switch_ctrl.sv
// Registered delay line with a glitch-free tap switch: dout freezes for SETTLE
// cycles on every tap change before the new tap starts driving it.
module delay_tap_switch_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 3,
  parameter int TAPW     = 2,
  parameter int SETTLE   = 2,
  parameter int INIT_TAP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        din,
  delay_tap_switch_ctrl_if.slave  req,
  output logic [WIDTH-1:0]        dout,
  output logic [TAPW-1:0]         cur_tap,
  output logic                    busy,
  output logic                    switch_done,
  output logic                    err
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam int              CNTW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE - 1);
  localparam logic [TAPW:0]   DEPTH_L  = (TAPW + 1)'(DEPTH);

  logic [0:0]       state;
  logic [CNTW-1:0]  cnt;
  logic [TAPW-1:0]  pend;
  logic [WIDTH-1:0] line [DEPTH];

  logic accept;
  logic tap_bad;
  logic tap_same;

  assign req.req_ready = (state == ST_RUN);
  assign busy          = (state == ST_HOLD);
  assign accept        = req.req_valid && (state == ST_RUN);
  assign tap_bad       = {1'b0, req.req_tap} >= DEPTH_L;
  assign tap_same      = (req.req_tap == cur_tap);

  // NOTE: the line is only DEPTH registers, so it is reset explicitly;
  // otherwise dout would replay pre-reset garbage for DEPTH cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) line[k] <= '0;
    end else begin
      line[0] <= din;
      for (int k = 1; k < DEPTH; k++) line[k] <= line[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      cnt         <= '0;
      pend        <= TAPW'(INIT_TAP);
      cur_tap     <= TAPW'(INIT_TAP);
      dout        <= '0;
      switch_done <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: pulses default low here; a later non-blocking assignment in the
      // same edge overrides this one, giving clean single-cycle strobes.
      switch_done <= 1'b0;
      err         <= 1'b0;
      if (state == ST_RUN) begin
        dout <= line[cur_tap];
        if (accept) begin
          if (tap_bad) begin
            err <= 1'b1;
          end else if (!tap_same) begin
            pend  <= req.req_tap;
            cnt   <= CNT_LOAD;
            state <= ST_HOLD;
          end
        end
      end else begin
        // dout is deliberately not loaded while holding.
        if (cnt != '0) begin
          cnt <= cnt - CNTW'(1);
        end else begin
          cur_tap     <= pend;
          switch_done <= 1'b1;
          state       <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_delay_tap_switch_ctrl.sv
// Bench for delay_tap_switch_ctrl: directed scenarios plus random traffic,
// every cycle compared against a history-based reference model.
module tb_delay_tap_switch_ctrl;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 3;
  localparam int TAPW     = 2;
  localparam int SETTLE   = 2;
  localparam int INIT_TAP = 0;
  localparam int HIST     = 4096;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic [TAPW-1:0]  cur_tap;
  logic             busy;
  logic             switch_done;
  logic             err;

  delay_tap_switch_ctrl_if #(.TAPW(TAPW)) req_if ();

  delay_tap_switch_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TAPW(TAPW), .SETTLE(SETTLE), .INIT_TAP(INIT_TAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .req        (req_if.slave),
    .dout       (dout),
    .cur_tap    (cur_tap),
    .busy       (busy),
    .switch_done(switch_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the line is the recorded history of din, cut off at the
  // most recent reset; a tap change freezes dout for SETTLE edges.
  logic [WIDTH-1:0] hist [HIST];
  int               edge_n   = 0;
  int               last_rst = -1;
  int               m_cur    = INIT_TAP;
  int               m_hold   = 0;
  int               m_pend   = INIT_TAP;
  logic [WIDTH-1:0] m_dout   = '0;
  bit               m_err    = 1'b0;
  bit               m_done   = 1'b0;
  bit               m_accept = 1'b0;
  bit               cnt_mode = 1'b0;
  int               done_seen = 0;

  function automatic logic [WIDTH-1:0] line_val(input int j);
    return (j >= 0 && j > last_rst) ? hist[j] : '0;
  endfunction

  task automatic step();
    if (cnt_mode) din = WIDTH'(edge_n + 1);
    @(posedge clk);
    edge_n++;
    m_accept = 1'b0;
    if (rst) begin
      hist[edge_n] = '0;
      last_rst     = edge_n;
      m_cur        = INIT_TAP;
      m_hold       = 0;
      m_dout       = '0;
      m_err        = 1'b0;
      m_done       = 1'b0;
    end else begin
      hist[edge_n] = din;
      m_err        = 1'b0;
      m_done       = 1'b0;
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin
          m_cur  = m_pend;
          m_done = 1'b1;
        end
      end else begin
        m_dout = line_val(edge_n - 1 - m_cur);
        if (req_if.req_valid) begin
          m_accept = 1'b1;
          if (int'(req_if.req_tap) >= DEPTH) begin
            m_err = 1'b1;
          end else if (int'(req_if.req_tap) != m_cur) begin
            m_pend = int'(req_if.req_tap);
            m_hold = SETTLE;
          end
        end
      end
    end
    #1;
    check("dout",        dout,             m_dout);
    check("cur_tap",     cur_tap,          m_cur);
    check("busy",        busy,             m_hold > 0);
    check("req_ready",   req_if.req_ready, m_hold == 0);
    check("switch_done", switch_done,      m_done);
    check("err",         err,              m_err);
    check("err_done_excl", switch_done & err, 1'b0);
    check("tap_in_range",  cur_tap < DEPTH,   1'b1);
    if (switch_done === 1'b1) done_seen++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] frozen;
    int               d0;
    bit               got_accept;

    req_if.req_valid = 1'b0;
    req_if.req_tap   = '0;

    // 1: reset, then a held constant reaches dout two edges later.
    rst = 1'b1; din = 8'hA5;
    step(); step();
    check("t1_dout_in_reset", dout, 8'h00);
    rst = 1'b0;
    step();
    step();
    check("t1_dout_a5", dout, 8'hA5);
    check("t1_cur_tap", cur_tap, 0);
    check("t1_busy", busy, 1'b0);

    cnt_mode = 1'b1;
    step(); step();

    // 3: out-of-range tap.
    req_if.req_valid = 1'b1; req_if.req_tap = 2'd3;
    step();
    req_if.req_valid = 1'b0;
    check("t3_err", err, 1'b1);
    check("t3_cur_tap", cur_tap, 0);
    check("t3_ready", req_if.req_ready, 1'b1);
    check("t3_busy", busy, 1'b0);
    step();
    check("t3_err_single", err, 1'b0);

    // 4: same-tap request is a no-op.
    req_if.req_valid = 1'b1; req_if.req_tap = 2'd0;
    step();
    req_if.req_valid = 1'b0;
    check("t4_busy", busy, 1'b0);
    check("t4_done", switch_done, 1'b0);
    check("t4_err", err, 1'b0);
    check("t4_dout_track", dout, WIDTH'(edge_n - 1));

    // 5: reset during the first HOLD cycle discards the switch.
    req_if.req_valid = 1'b1; req_if.req_tap = 2'd2;
    step();
    req_if.req_valid = 1'b0;
    check("t5_busy_after_accept", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_cur_tap", cur_tap, 0);
    check("t5_dout", dout, 8'h00);
    check("t5_busy", busy, 1'b0);
    check("t5_ready", req_if.req_ready, 1'b1);
    d0 = done_seen;
    for (int i = 0; i < 5; i++) step();
    check("t5_no_done", done_seen - d0, 0);

    // 2: switch 0 -> 2 with din as a cycle counter.
    check("t2_dout_tap0", dout, WIDTH'(edge_n - 1));
    req_if.req_valid = 1'b1; req_if.req_tap = 2'd2;
    step();
    req_if.req_valid = 1'b0;
    frozen = dout;
    check("t2_e0_old_tap", dout, WIDTH'(edge_n - 1));
    check("t2_e0_busy", busy, 1'b1);
    step();
    check("t2_e1_frozen", dout, frozen);
    check("t2_e1_busy", busy, 1'b1);
    step();
    check("t2_e2_frozen", dout, frozen);
    check("t2_e2_done", switch_done, 1'b1);
    check("t2_e2_cur_tap", cur_tap, 2);
    step();
    check("t2_new_tap_dout", dout, WIDTH'(edge_n - 3));
    check("t2_done_single", switch_done, 1'b0);
    step(); step();
    check("t2_dout_tap2", dout, WIDTH'(edge_n - 3));

    // 6: request held across a HOLD is taken on the first RUN cycle.
    d0 = done_seen;
    req_if.req_valid = 1'b1; req_if.req_tap = 2'd1;
    step();
    check("t6_ready_low", req_if.req_ready, 1'b0);
    req_if.req_tap = 2'd2;
    got_accept = 1'b0;
    for (int i = 0; i < 10 && !got_accept; i++) begin
      step();
      got_accept = m_accept;
    end
    req_if.req_valid = 1'b0;
    check("t6_accepted", got_accept, 1'b1);
    check("t6_mid_cur_tap", cur_tap, 1);
    check("t6_second_busy", busy, 1'b1);
    step(); step();
    check("t6_final_cur_tap", cur_tap, 2);
    check("t6_done_count", done_seen - d0, 2);

    // Random traffic.
    cnt_mode = 1'b0;
    for (int i = 0; i < 500; i++) begin
      din              = WIDTH'($urandom);
      rst              = ($urandom_range(0, 99) < 2);
      req_if.req_valid = ($urandom_range(0, 2) == 0);
      req_if.req_tap   = TAPW'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; req_if.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
